gpio_cmd_ctrl: RTL and testbench
================================

GPIO_CMD_CTRL -- requirements
Module: gpio_cmd_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): NB_GPIO, 32, GPIO word width; NB_DATA, 24, pixel/kernel payload width; NB_IMAGE, 10, image length width; NB_RESULT, 16, convolution result width.
REQ-002 SHALL have the ports, one per line (name, direction, width, meaning):
  i_CLK  in  1  single clock.
  i_reset  in  1  reset; synchronous, active-high.
  i_gpioData  in  NB_GPIO  micro command word: [31:29] opcode, [28] toggle, [NB_DATA-1:0] payload.
  i_EoP  in  1  end of processing, from address FSM.
  i_resultVld  in  1  result strobe, from convolver.
  i_result  in  NB_RESULT  convolution result.
  o_gpioData  out  NB_GPIO  status/read-back word.
  o_SoP  out  1  start-of-processing pulse to FSM.
  o_load  out  1  memory-load level to FSM.
  o_valid  out  1  one-cycle data-valid to FSM.
  o_imgLength  out  NB_IMAGE  latched image length.
  o_data  out  NB_DATA  latched pixel payload.
  o_kernel  out  NB_DATA  latched kernel payload.
  o_kernelVld  out  1  one-cycle kernel-valid.

Function
REQ-003 SHALL register i_gpioData once; a new command exists when the registered toggle differs from the previously registered toggle (either edge).
REQ-004 SHALL drive each command's outputs registered, exactly 2 cycles after the first clock edge that samples the new toggle; a held word SHALL never re-execute.
REQ-005 SHALL decode opcodes: 000 CLR, 001 SOFT_RST, 010 SET_LEN, 011 LOAD_KER, 100 LOAD_DATA, 101 END_LOAD, 110 START, 111 reserved.
REQ-006 SHALL implement states IDLE, LOAD, READY, RUN, DONE; reset and SOFT_RST enter IDLE.
REQ-007 IDLE/READY/DONE + LOAD_DATA -> LOAD: o_load=1, o_data=payload, o_valid pulses 1 cycle; DONE also clears the done flag.
REQ-008 LOAD + LOAD_DATA -> stay: o_data=payload, o_valid pulses; LOAD + END_LOAD -> READY, o_load=0.
REQ-009 READY + START -> RUN: o_SoP high exactly 1 cycle; START in any other state -> ignored, error set.
REQ-010 RUN + LOAD_DATA -> o_data=payload, o_valid pulses, o_load stays 0; RUN + i_EoP -> DONE, done flag set.
REQ-011 i_EoP coincident with a RUN data command: both execute (valid pulse and DONE transition).
REQ-012 SET_LEN SHALL latch payload[NB_IMAGE-1:0] into o_imgLength in IDLE/READY/DONE only; in LOAD/RUN ignored, error set.
REQ-013 LOAD_KER SHALL latch o_kernel and pulse o_kernelVld in any state except RUN (RUN -> ignored, error).
REQ-014 END_LOAD outside LOAD, opcode 111 -> no state change, error set; CLR clears error and done, no state change.
REQ-015 SHALL capture i_result on i_resultVld into the result field, holding until the next strobe.
REQ-016 o_gpioData SHALL be [31] last executed toggle (ack), [30] busy (RUN), [29] done, [28] error, [27:25] state code, [24:NB_RESULT] zero, [NB_RESULT-1:0] result.
REQ-017 i_EoP outside RUN SHALL be ignored.

Reset
REQ-018 On i_reset all outputs SHALL be 0, o_imgLength 0, state IDLE, flags 0, and the toggle history SHALL load the current registered toggle so no command fires after reset.
REQ-019 SOFT_RST SHALL equal i_reset except o_gpioData[31] reflects the soft-reset toggle; reset mid-RUN aborts with no o_SoP/o_valid.

Structure
REQ-020 Package gpio_cmd_pkg SHALL hold opcode constants, state encodings and o_gpioData bit positions.
REQ-021 Toggle edge detection SHALL be one sub-module, toggle_detect (register + XOR, one-cycle new-command pulse).

Verification
REQ-022 Reset, SET_LEN 9 (toggle 0->1) -> o_imgLength=9 two cycles after sampling, ack bit=1, no valid pulse.
REQ-023 LOAD_DATA x10 toggling, END_LOAD -> o_load 1 through 10 single-cycle o_valid pulses with payloads 1..10 on o_data, then o_load 0, state READY.
REQ-024 START from READY -> o_SoP one cycle, busy=1; 10 LOAD_DATA -> 10 o_valid; i_EoP -> done=1, busy=0.
REQ-025 START in IDLE, SET_LEN in RUN, opcode 111 -> error=1, state unchanged; CLR -> error=0.
REQ-026 Word held constant 100 cycles -> exactly one execution; i_resultVld with 0x1234 -> o_gpioData[15:0]=0x1234.
REQ-027 i_reset asserted mid-RUN with toggle pending -> all outputs 0, IDLE, no command executes afterward.

Source files
------------

// File: rtl/gpio_cmd_pkg.sv
// gpio_cmd_pkg
// Shared definitions for the GPIO command controller: command opcodes,
// controller state encodings, and bit positions of the command word
// (i_gpioData) and the status word (o_gpioData).
package gpio_cmd_pkg;

  typedef enum logic [2:0] {
    OP_CLR       = 3'd0,
    OP_SOFT_RST  = 3'd1,
    OP_SET_LEN   = 3'd2,
    OP_LOAD_KER  = 3'd3,
    OP_LOAD_DATA = 3'd4,
    OP_END_LOAD  = 3'd5,
    OP_START     = 3'd6,
    OP_RSVD      = 3'd7
  } opcode_e;

  // The encoding is also the state code reported in o_gpioData[27:25].
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Command word fields
  localparam int unsigned CMD_OP_MSB  = 31;
  localparam int unsigned CMD_OP_LSB  = 29;
  localparam int unsigned CMD_TOG_BIT = 28;

  // Status word fields
  localparam int unsigned ST_ACK_BIT  = 31;
  localparam int unsigned ST_BUSY_BIT = 30;
  localparam int unsigned ST_DONE_BIT = 29;
  localparam int unsigned ST_ERR_BIT  = 28;
  localparam int unsigned ST_CODE_MSB = 27;
  localparam int unsigned ST_CODE_LSB = 25;

  // States in which image length may be set and a fresh memory load may begin.
  function automatic logic accepts_setup(state_e s);
    return (s == ST_IDLE) || (s == ST_READY) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/toggle_detect.sv
// toggle_detect
// Turns a change of the command toggle bit (either direction) into a
// single-cycle registered new-command pulse.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   tog_i  : registered toggle bit of the command word
//   new_o  : one-cycle pulse, one clock after tog_i changes
module toggle_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tog_i,
  output logic new_o
);

  logic prev_q;
  logic pulse_q;

  // During reset the history tracks the live toggle, so a word that is
  // already present when reset is released is never treated as new.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= tog_i;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= tog_i;
      pulse_q <= tog_i ^ prev_q;
    end
  end

  assign new_o = pulse_q;

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// gpio_cmd_ctrl
// Decodes toggle-handshaked micro commands arriving on a GPIO word and drives
// the image-processing control signals; reports status on a read-back word.
//   i_CLK, i_reset   : clock, synchronous active-high reset
//   i_gpioData       : command word {opcode[31:29], toggle[28], payload}
//   i_EoP            : end of processing (honoured only while RUN)
//   i_resultVld/i_result : convolution result strobe and value
//   o_gpioData       : {ack, busy, done, error, state[2:0], 0..., result}
//   o_SoP            : start-of-processing pulse
//   o_load           : memory-load level (state LOAD)
//   o_valid/o_data   : data pulse and latched pixel payload
//   o_kernelVld/o_kernel : kernel pulse and latched kernel payload
//   o_imgLength      : latched image length
module gpio_cmd_ctrl
  import gpio_cmd_pkg::*;
#(
  parameter int NB_GPIO   = 32,
  parameter int NB_DATA   = 24,
  parameter int NB_IMAGE  = 10,
  parameter int NB_RESULT = 16
) (
  input  logic                 i_CLK,
  input  logic                 i_reset,
  input  logic [NB_GPIO-1:0]   i_gpioData,
  input  logic                 i_EoP,
  input  logic                 i_resultVld,
  input  logic [NB_RESULT-1:0] i_result,
  output logic [NB_GPIO-1:0]   o_gpioData,
  output logic                 o_SoP,
  output logic                 o_load,
  output logic                 o_valid,
  output logic [NB_IMAGE-1:0]  o_imgLength,
  output logic [NB_DATA-1:0]   o_data,
  output logic [NB_DATA-1:0]   o_kernel,
  output logic                 o_kernelVld
);

  // Command pipeline: gpio_q samples the bus, cmd_q aligns the word with the
  // detector pulse, and the decode below registers the effect one clock later.
  logic [NB_GPIO-1:0] gpio_q;
  logic [NB_GPIO-1:0] cmd_q;
  logic               cmd_new;

  always_ff @(posedge i_CLK) begin
    gpio_q <= i_gpioData;
    cmd_q  <= gpio_q;
  end

  toggle_detect u_toggle_detect (
    .clk_i (i_CLK),
    .rst_i (i_reset),
    .tog_i (gpio_q[CMD_TOG_BIT]),
    .new_o (cmd_new)
  );

  // Command word bits between payload and toggle carry no meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{gpio_q[CMD_TOG_BIT-1:NB_DATA], cmd_q[CMD_TOG_BIT-1:NB_DATA]};

  opcode_e              op;
  logic [NB_DATA-1:0]   payload;
  assign op      = opcode_e'(cmd_q[CMD_OP_MSB:CMD_OP_LSB]);
  assign payload = cmd_q[NB_DATA-1:0];

  state_e                state_q,  state_d;
  logic                  ack_q,    ack_d;
  logic                  done_q,   done_d;
  logic                  err_q,    err_d;
  logic                  load_q,   load_d;
  logic                  valid_q,  valid_d;
  logic                  sop_q,    sop_d;
  logic                  kvld_q,   kvld_d;
  logic [NB_DATA-1:0]    data_q,   data_d;
  logic [NB_DATA-1:0]    kernel_q, kernel_d;
  logic [NB_IMAGE-1:0]   len_q,    len_d;
  logic [NB_RESULT-1:0]  result_q, result_d;
  logic                  soft_rst;

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      kvld_q   <= 1'b0;
      data_q   <= '0;
      kernel_q <= '0;
      len_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      load_q   <= load_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      kvld_q   <= kvld_d;
      data_q   <= data_d;
      kernel_q <= kernel_d;
      len_q    <= len_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    done_d   = done_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    kvld_d   = 1'b0;
    data_d   = data_q;
    kernel_d = kernel_q;
    len_d    = len_q;
    result_d = i_resultVld ? i_result : result_q;
    soft_rst = 1'b0;

    if (cmd_new) begin
      ack_d = cmd_q[CMD_TOG_BIT];
      case (op)
        OP_CLR: begin
          err_d  = 1'b0;
          done_d = 1'b0;
        end
        OP_SOFT_RST: soft_rst = 1'b1;
        OP_SET_LEN: begin
          if (accepts_setup(state_q)) len_d = payload[NB_IMAGE-1:0];
          else                        err_d = 1'b1;
        end
        OP_LOAD_KER: begin
          if (state_q != ST_RUN) begin
            kernel_d = payload;
            kvld_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_LOAD_DATA: begin
          // Accepted in every state; only setup states move into LOAD.
          data_d  = payload;
          valid_d = 1'b1;
          if (accepts_setup(state_q)) begin
            state_d = ST_LOAD;
            if (state_q == ST_DONE) done_d = 1'b0;
          end
        end
        OP_END_LOAD: begin
          if (state_q == ST_LOAD) state_d = ST_READY;
          else                    err_d   = 1'b1;
        end
        OP_START: begin
          if (state_q == ST_READY) begin
            state_d = ST_RUN;
            sop_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end

    // End of processing is independent of the command path, so a RUN data
    // command and i_EoP in the same cycle both take effect.
    if (state_q == ST_RUN && i_EoP) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
    end

    // Soft reset overrides everything above except the acknowledge bit.
    if (soft_rst) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      err_d    = 1'b0;
      valid_d  = 1'b0;
      sop_d    = 1'b0;
      kvld_d   = 1'b0;
      data_d   = '0;
      kernel_d = '0;
      len_d    = '0;
      result_d = '0;
    end

    load_d = (state_d == ST_LOAD);
  end

  always_comb begin
    o_gpioData                          = '0;
    o_gpioData[ST_ACK_BIT]              = ack_q;
    o_gpioData[ST_BUSY_BIT]             = (state_q == ST_RUN);
    o_gpioData[ST_DONE_BIT]             = done_q;
    o_gpioData[ST_ERR_BIT]              = err_q;
    o_gpioData[ST_CODE_MSB:ST_CODE_LSB] = state_q;
    o_gpioData[NB_RESULT-1:0]           = result_q;
  end

  assign o_SoP       = sop_q;
  assign o_load      = load_q;
  assign o_valid     = valid_q;
  assign o_imgLength = len_q;
  assign o_data      = data_q;
  assign o_kernel    = kernel_q;
  assign o_kernelVld = kvld_q;

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// tb_gpio_cmd_ctrl
// Scoreboard bench: each issued command is run through a behavioural model
// that queues the pulses it should cause; a monitor pops the queue whenever
// the DUT pulses o_valid, o_kernelVld or o_SoP. Status/length are checked by
// the stimulus tasks once each command has had time to execute.
module tb_gpio_cmd_ctrl;
  import gpio_cmd_pkg::*;

  localparam int NB_GPIO   = 32;
  localparam int NB_DATA   = 24;
  localparam int NB_IMAGE  = 10;
  localparam int NB_RESULT = 16;

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic [NB_GPIO-1:0]   i_gpioData;
  logic                 i_EoP;
  logic                 i_resultVld;
  logic [NB_RESULT-1:0] i_result;
  logic [NB_GPIO-1:0]   o_gpioData;
  logic                 o_SoP, o_load, o_valid, o_kernelVld;
  logic [NB_IMAGE-1:0]  o_imgLength;
  logic [NB_DATA-1:0]   o_data, o_kernel;

  gpio_cmd_ctrl #(
    .NB_GPIO   (NB_GPIO),
    .NB_DATA   (NB_DATA),
    .NB_IMAGE  (NB_IMAGE),
    .NB_RESULT (NB_RESULT)
  ) dut (
    .i_CLK       (clk),
    .i_reset     (i_reset),
    .i_gpioData  (i_gpioData),
    .i_EoP       (i_EoP),
    .i_resultVld (i_resultVld),
    .i_result    (i_result),
    .o_gpioData  (o_gpioData),
    .o_SoP       (o_SoP),
    .o_load      (o_load),
    .o_valid     (o_valid),
    .o_imgLength (o_imgLength),
    .o_data      (o_data),
    .o_kernel    (o_kernel),
    .o_kernelVld (o_kernelVld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int n_valid = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected pulse events: kind 0 = data valid, 1 = kernel valid, 2 = SoP
  typedef struct {
    int          kind;
    logic [23:0] val;
    int          at;
    logic        load;
  } ev_t;
  ev_t exp_q[$];

  task automatic push_ev(int kind, logic [23:0] val, int at, logic load);
    ev_t e;
    e.kind = kind; e.val = val; e.at = at; e.load = load;
    exp_q.push_back(e);
  endtask

  task automatic take(int kind, logic [23:0] v, logic ld);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_pulse: got kind %0d value 0x%0h expected no pulse (cycle %0d)", kind, v, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.at);
      chk("pulse_payload", v, e.val);
      if (kind == 0) chk("load_at_valid", ld, e.load);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (o_valid) begin
        n_valid++;
        take(0, o_data, o_load);
      end
      if (o_kernelVld) take(1, o_kernel, 1'b0);
      if (o_SoP)       take(2, '0, 1'b0);
    end
  end

  // Reference model of the controller's visible state
  state_e          m_state;
  logic            m_ack, m_done, m_err, tog_now;
  logic [9:0]      m_len;
  logic [15:0]     m_result;

  function automatic logic [31:0] exp_word();
    return {m_ack, m_state == ST_RUN, m_done, m_err, m_state, 9'b0, m_result};
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_ack = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_len = '0; m_result = '0;
  endtask

  task automatic model_cmd(int op, logic [23:0] pay, int at);
    bit setup;
    setup = (m_state == ST_IDLE) || (m_state == ST_READY) || (m_state == ST_DONE);
    m_ack = tog_now;
    case (op)
      0: begin m_err = 1'b0; m_done = 1'b0; end
      1: begin
        m_state = ST_IDLE; m_err = 1'b0; m_done = 1'b0; m_len = '0; m_result = '0;
      end
      2: if (setup) m_len = pay[9:0]; else m_err = 1'b1;
      3: if (m_state != ST_RUN) push_ev(1, pay, at, 1'b0); else m_err = 1'b1;
      4: begin
        if (m_state == ST_DONE) m_done = 1'b0;
        if (setup) m_state = ST_LOAD;
        push_ev(0, pay, at, m_state == ST_LOAD);
      end
      5: if (m_state == ST_LOAD) m_state = ST_READY; else m_err = 1'b1;
      6: if (m_state == ST_READY) begin
        m_state = ST_RUN;
        push_ev(2, '0, at, 1'b0);
      end else m_err = 1'b1;
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic drive_word(int op, logic [23:0] pay);
    logic [2:0] op3;
    op3 = op[2:0];
    tog_now    = ~tog_now;
    i_gpioData = {op3, tog_now, 4'b0000, pay};
  endtask

  // Issue one command; optionally raise i_EoP on the cycle it executes.
  task automatic issue(int op, logic [23:0] pay, bit eop_at_exec = 1'b0);
    int   k;
    logic old_ack;
    @(negedge clk);
    drive_word(op, pay);
    k       = cyc;
    old_ack = m_ack;
    model_cmd(op, pay, k + 3);
    @(negedge clk);
    @(negedge clk);
    chk("ack_not_early", o_gpioData[31], old_ack);
    if (eop_at_exec) i_EoP = 1'b1;
    @(negedge clk);
    i_EoP = 1'b0;
    if (eop_at_exec && m_state == ST_RUN) begin
      m_state = ST_DONE;
      m_done  = 1'b1;
    end
    chk("status_word", o_gpioData, exp_word());
    chk("img_length", o_imgLength, m_len);
    chk("load_level", o_load, m_state == ST_LOAD);
    if (op == 1) begin
      chk("soft_rst_data", o_data, 0);
      chk("soft_rst_kernel", o_kernel, 0);
    end
  endtask

  task automatic eop_pulse();
    @(negedge clk);
    i_EoP = 1'b1;
    @(negedge clk);
    i_EoP = 1'b0;
    if (m_state == ST_RUN) begin
      m_state = ST_DONE;
      m_done  = 1'b1;
    end
    chk("status_after_eop", o_gpioData, exp_word());
  endtask

  task automatic result_pulse(logic [15:0] v);
    @(negedge clk);
    i_resultVld = 1'b1;
    i_result    = v;
    @(negedge clk);
    i_resultVld = 1'b0;
    m_result    = v;
    chk("result_field", o_gpioData[15:0], v);
  endtask

  // Reset asserted from the next negedge; anything in the command pipeline is dropped.
  task automatic hard_reset();
    @(negedge clk);
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    chk("reset_status", o_gpioData, exp_word());
    chk("reset_outputs", {o_SoP, o_load, o_valid, o_kernelVld}, 0);
    chk("reset_len", o_imgLength, 0);
    chk("reset_data", o_data, 0);
    chk("reset_kernel", o_kernel, 0);
  endtask

  initial begin
    int nv;
    int r;
    i_reset     = 1'b1;
    i_gpioData  = '0;
    i_EoP       = 1'b0;
    i_resultVld = 1'b0;
    i_result    = '0;
    tog_now     = 1'b0;
    model_reset();
    hard_reset();

    // First command: length 9, toggle 0 -> 1
    issue(2, 24'd9);
    chk("first_ack", o_gpioData[31], 1'b1);

    // Load ten pixels then close the load
    for (int i = 1; i <= 10; i++) issue(4, 24'(i));
    issue(5, '0);

    // Run with ten data words, then end of processing
    issue(6, '0);
    chk("busy_in_run", o_gpioData[30], 1'b1);
    for (int i = 0; i < 10; i++) issue(4, 24'($urandom));
    eop_pulse();
    chk("done_after_eop", o_gpioData[29], 1'b1);

    // Error paths
    issue(1, '0);
    issue(6, '0);
    issue(0, '0);
    issue(4, 24'h00abcd);
    issue(5, '0);
    issue(6, '0);
    issue(2, 24'd33);
    issue(7, 24'h123456);
    issue(3, 24'h0f0f0f);
    issue(0, '0);

    // Data command coincident with end of processing
    issue(4, 24'h5a5a5a, 1'b1);
    chk("done_coincident", o_gpioData[29], 1'b1);

    // Kernel load and a word held long after its single execution
    issue(3, 24'($urandom));
    nv = n_valid;
    issue(4, 24'h777777);
    repeat (100) @(negedge clk);
    chk("held_word_once", n_valid - nv, 1);
    result_pulse(16'h1234);

    // Hard reset with a command in flight during RUN
    issue(5, '0);
    issue(6, '0);
    nv = n_valid;
    @(negedge clk);
    drive_word(4, 24'h654321);
    hard_reset();
    chk("no_exec_after_reset", n_valid - nv, 0);

    // Randomized traffic
    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r < 8)       issue(r, 24'($urandom));
      else if (r == 8) eop_pulse();
      else             result_pulse(16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
